// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit per
// clock through one full_subtractor cell and a borrow flip-flop.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold last result
// ST_SHIFT | one operand bit per edge through the cell, busy=1
// ST_DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bin_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The unused encoding 2'd3 is treated like IDLE, so it can also accept.
    always_comb begin
        accept   = start && (state_q != ST_SHIFT);
        last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
        state_d  = state_q;
        case (state_q)
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_d = accept ? ST_SHIFT : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == ST_SHIFT) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {cell_d, res_sr[WIDTH-1:1]};
            bin_q  <= cell_bout;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Results move only on the completion edge; bin_q is the borrow into the MSB there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (last_bit) begin
            diff_q     <= {cell_d, res_sr[WIDTH-1:1]};
            borrow_q   <= cell_bout;
            overflow_q <= bin_q ^ cell_bout;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner
// sequences and random operands against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    int n_chk;
    int n_pass;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] e_diff;
        logic       e_borrow;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        int         sd;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        d  = 8'((int'(x) - int'(y) + 256) % 256);
        bo = (int'(x) < int'(y));
        sd = int'($signed(x)) - int'($signed(y));
        ov = (sd > 127) || (sd < -128);
        return {ov, bo, d};
    endfunction

    // One request; observes 9 edges after the accepting edge.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag,
                          output logic [7:0] r_diff, output logic r_borrow, output logic r_ovf);
        logic [7:0] prev;
        int         busy_n;
        int         done_at;
        int         done_n;
        logic       held;
        logic       both;
        prev     = diff;
        busy_n   = 0;
        done_at  = -1;
        done_n   = 0;
        held     = 1'b1;
        both     = 1'b0;
        r_diff   = 8'h00;
        r_borrow = 1'b0;
        r_ovf    = 1'b0;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy) busy_n++;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (busy && done) both = 1'b1;
            if (k < 8 && diff !== prev) held = 1'b0;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at  = k;
                    r_diff   = diff;
                    r_borrow = borrow;
                    r_ovf    = overflow;
                end
            end
        end
        chk({tag, "_latency"}, 32'(done_at), 32'd8);
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        chk({tag, "_held"}, {31'd0, held}, 32'd1);
        chk({tag, "_busy_done_overlap"}, {31'd0, both}, 32'd0);
    endtask

    initial begin
        logic [7:0] r_diff;
        logic       r_borrow;
        logic       r_ovf;
        logic [9:0] m;
        logic       seen_done;
        logic [7:0] ra;
        logic [7:0] rb;

        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_diff", {24'd0, diff}, 32'd0);
        chk("reset_borrow", {31'd0, borrow}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, $sformatf("vec%0d", i), r_diff, r_borrow, r_ovf);
            chk($sformatf("vec%0d_diff", i), {24'd0, r_diff}, {24'd0, vecs[i].e_diff});
            chk($sformatf("vec%0d_borrow", i), {31'd0, r_borrow}, {31'd0, vecs[i].e_borrow});
            chk($sformatf("vec%0d_overflow", i), {31'd0, r_ovf}, {31'd0, vecs[i].e_ovf});
        end

        // start held high; operands and start wiggle mid-SHIFT; re-accept in DONE.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'hFF;
        seen_done = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
            if (k == 7) begin
                a = 8'h00;
                b = 8'h00;
            end
        end
        chk("held_start_early_done", {31'd0, seen_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_start_done", {31'd0, done}, 32'd1);
        chk("held_start_diff", {24'd0, diff}, 32'h0F);
        chk("held_start_borrow", {31'd0, borrow}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        seen_done = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("b2b_early_done", {31'd0, seen_done}, 32'd0);
        chk("b2b_diff_held", {24'd0, diff}, 32'h0F);
        @(posedge clk);
        #1;
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_diff", {24'd0, diff}, 32'h00);
        chk("b2b_borrow", {31'd0, borrow}, 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        run_op(8'h05, 8'h03, "pre_rst", r_diff, r_borrow, r_ovf);
        chk("pre_rst_diff", {24'd0, r_diff}, 32'h02);
        @(negedge clk);
        a     = 8'h20;
        b     = 8'h10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_diff", {24'd0, diff}, 32'd0);
        chk("midrst_borrow", {31'd0, borrow}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("midrst_quiet", {31'd0, seen_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h20, 8'h10, "post_rst", r_diff, r_borrow, r_ovf);
        chk("post_rst_diff", {24'd0, r_diff}, 32'h10);
        chk("post_rst_borrow", {31'd0, r_borrow}, 32'd0);
        chk("post_rst_overflow", {31'd0, r_ovf}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            m  = model(ra, rb);
            run_op(ra, rb, $sformatf("rnd%0d", i), r_diff, r_borrow, r_ovf);
            chk($sformatf("rnd%0d_diff a=%0h b=%0h", i, ra, rb), {24'd0, r_diff}, {24'd0, m[7:0]});
            chk($sformatf("rnd%0d_borrow a=%0h b=%0h", i, ra, rb), {31'd0, r_borrow}, {31'd0, m[8]});
            chk($sformatf("rnd%0d_overflow a=%0h b=%0h", i, ra, rb), {31'd0, r_ovf}, {31'd0, m[9]});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the sequential, inverse-operation counterpart of the team's full-adder datapath cell. It is intended for area-constrained arithmetic paths where latency of WIDTH cycles is acceptable. It uses a start/busy/done handshake and holds its results until the next completion.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  minuend; sampled on the accepting edge only.
b  input  WIDTH  subtrahend; sampled on the accepting edge only.
busy  output  1  high while in SHIFT.
done  output  1  single-cycle pulse; results valid from this cycle onward.
diff  output  WIDTH  registered result a - b, modulo 2^WIDTH.
borrow  output  1  unsigned borrow-out; 1 iff a < b unsigned.
overflow  output  1  signed overflow: borrow into MSB XOR borrow out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrow=0, overflow=0; internal shift registers, bit counter and borrow FF cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE. Encoding is binary, 2 bits.
- IDLE: if start=1 on an edge, the block accepts the request (edge 0):
  - a and b load into operand shift registers; the borrow FF is cleared; the counter is set to 0; the next state is SHIFT and busy=1.
  - Otherwise the block stays in IDLE.
- SHIFT: on each edge k (k = 1..WIDTH), the cell computes on the operand LSBs and the borrow FF:
  - d = a0 ^ b0 ^ bin
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
  - d shifts into the MSB of the result shift register; the operands shift right; the borrow FF takes bout; the counter increments.
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1), diff is loaded from the completed result and borrow from bout. overflow is loaded from (bin at MSB) ^ bout. The next state is DONE, with busy=0 and done=1.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge.
- start is ignored in SHIFT, and operand changes there have no effect.
- DONE: done=1 for exactly one cycle.
  - If start=1 on this edge, a new request is accepted exactly as in IDLE (back-to-back, next state SHIFT).
  - Otherwise the next state is IDLE.
- diff, borrow and overflow change only on the completion edge, or on reset. They hold stable through IDLE and through the following SHIFT phase.
- busy and done are never high simultaneously.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package/header serial_sub_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 unreachable; decodes to IDLE);
  - counter width constant CNT_W = clog2(WIDTH).
- One natural sub-module: full_subtractor (ports a, b, bin, d, bout), purely combinational and gate-level. It is instantiated once as the serial cell.
- The FSM, counter, shift registers and output registers live in the top level.

Test Plan:
WIDTH=8, reset released, start=1 with a=0x05, b=0x03 -> busy high for 8 cycles, then done pulse; diff=0x02, borrow=0, overflow=0.
a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0; done exactly 8 edges after the accepting edge.
a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1; then a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
start held high with a=0x10, b=0x01 accepted; operands changed to 0xFF/0xFF and start pulsed again mid-SHIFT -> single done, diff=0x0F. start=1 in the DONE cycle with a=0x00, b=0x00 -> second done 8 edges later, diff=0x00, borrow=0.
rst_n asserted at SHIFT cycle 4 of a=0x20, b=0x10 -> all outputs 0 immediately (asynchronous), no done pulse; after release, a new request completes correctly.
